// File: rtl/ysyx_25040109_lsu_sb.sv
// Load/store unit with a posted store buffer: aligned stores complete to WB at once
// and drain to memory in order; a load waits while an older store to its word is buffered.
module ysyx_25040109_lsu_sb #(
  parameter int XLEN     = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              out_ready,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   store_data,
  input  logic [2:0]        funct3,
  input  logic              is_load,
  input  logic              is_store,
  output logic              dmem_arvalid,
  input  logic              dmem_arready,
  output logic [XLEN-1:0]   dmem_araddr,
  input  logic              dmem_rvalid,
  output logic              dmem_rready,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              dmem_wvalid,
  input  logic              dmem_wready,
  output logic [XLEN-1:0]   dmem_waddr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_wstrb,
  output logic              out_valid,
  input  logic              in_ready,
  output logic [XLEN-1:0]   load_data,
  output logic              misalign,
  output logic              sb_empty
);
  localparam int PTR_W   = $clog2(SB_DEPTH);
  localparam int STRB_W  = XLEN / 8;
  localparam int WADDR_W = XLEN - 2;

  typedef enum logic [1:0] {IDLE, LD_REQ, LD_WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [WADDR_W-1:0]  sb_addr [SB_DEPTH];
  logic [STRB_W-1:0]   sb_strb [SB_DEPTH];
  logic [XLEN-1:0]     sb_data [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                sb_full, fire, push, pop, hazard, req_misalign;
  logic [STRB_W-1:0]   req_strb;

  logic [WADDR_W-1:0]  ld_word;
  logic [1:0]          ld_off;
  logic [2:0]          ld_funct3;
  logic [XLEN-1:0]     load_data_q, load_ext, rdata_shifted;
  logic                misalign_q;

  assign sb_full   = (count == (PTR_W+1)'(SB_DEPTH));
  assign sb_empty  = (count == '0);
  assign out_ready = (state == IDLE) && !sb_full;
  assign fire      = in_valid && out_ready;

  assign req_misalign = (is_load || is_store) &&
                        (((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));

  // A request flagged as both load and store is treated as a load.
  assign push = fire && is_store && !is_load && !req_misalign;
  assign pop  = dmem_wvalid && dmem_wready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    req_strb = '0;
    case (funct3[1:0])
      2'b00:   req_strb = STRB_W'(1) << addr[1:0];
      2'b01:   req_strb = STRB_W'(3) << addr[1:0];
      2'b10:   req_strb = '1;
      default: req_strb = '0;
    endcase
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (sb_valid[i] && (sb_addr[i] == ld_word)) hazard = 1'b1;
    end
  end

  always_comb begin
    rdata_shifted = dmem_rdata >> {ld_off, 3'b000};
    load_ext      = '0;
    case (ld_funct3)
      3'b000:  load_ext = {{(XLEN-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b001:  load_ext = {{(XLEN-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b010:  load_ext = rdata_shifted;
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, rdata_shifted[7:0]};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, rdata_shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire) state_nxt = (is_load && !req_misalign) ? LD_REQ : RESP;
      LD_REQ:  if (dmem_arvalid && dmem_arready) state_nxt = LD_WAIT;
      LD_WAIT: if (dmem_rvalid) state_nxt = RESP;
      RESP:    if (in_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ld_word     <= '0;
      ld_off      <= '0;
      ld_funct3   <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fire) begin
        ld_word     <= addr[XLEN-1:2];
        ld_off      <= addr[1:0];
        ld_funct3   <= funct3;
        load_data_q <= '0;
        misalign_q  <= req_misalign;
      end
      if ((state == LD_WAIT) && dmem_rvalid) load_data_q <= load_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      sb_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr           <= wr_ptr + 1'b1;
        sb_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr           <= rd_ptr + 1'b1;
        sb_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage has no reset; sb_valid and count decide what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[wr_ptr] <= addr[XLEN-1:2];
      sb_strb[wr_ptr] <= req_strb;
      sb_data[wr_ptr] <= store_data << {addr[1:0], 3'b000};
    end
  end

  assign dmem_arvalid = (state == LD_REQ) && !hazard;
  assign dmem_araddr  = {ld_word, 2'b00};
  assign dmem_rready  = (state == LD_WAIT);
  assign dmem_wvalid  = !sb_empty;
  assign dmem_waddr   = {sb_addr[rd_ptr], 2'b00};
  assign dmem_wdata   = sb_data[rd_ptr];
  assign dmem_wstrb   = sb_strb[rd_ptr];
  assign out_valid    = (state == RESP);
  assign load_data    = load_data_q;
  assign misalign     = misalign_q;

endmodule

// File: doc/ysyx_25040109_lsu_sb.md
YSYX_25040109_LSU_SB -- requirements
Module: ysyx_25040109_lsu_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width (32 only in this generation).
REQ-002 SHALL have parameter SB_DEPTH, default 4, meaning store-buffer entries (power of 2, 2..16).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports in_valid (input, 1) and out_ready (output, 1), the request handshake from EXU.
REQ-006 SHALL have request inputs addr (XLEN), store_data (XLEN), funct3 (3), is_load (1) and is_store (1).
REQ-007 SHALL have read-address ports dmem_arvalid (output, 1), dmem_arready (input, 1) and dmem_araddr (output, XLEN).
REQ-008 SHALL have read-data ports dmem_rvalid (input, 1), dmem_rready (output, 1) and dmem_rdata (input, XLEN).
REQ-009 SHALL have write ports dmem_wvalid (output, 1), dmem_wready (input, 1), dmem_waddr (output, XLEN, word-aligned), dmem_wdata (output, XLEN, lane-aligned) and dmem_wstrb (output, XLEN/8).
REQ-010 SHALL have response ports out_valid (output, 1), in_ready (input, 1), load_data (output, XLEN) and misalign (output, 1).
REQ-011 SHALL have output sb_empty, 1, high when the store buffer holds no entries (used for fence).

Function
REQ-012 SHALL run a main FSM with states IDLE, LD_REQ, LD_WAIT and RESP.
REQ-013 out_ready SHALL equal (state==IDLE && !sb_full); a request fires on in_valid && out_ready.
REQ-014 Request fire with neither is_load nor is_store SHALL go to RESP with load_data=0 and misalign=0.
REQ-015 Misalignment SHALL be LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
REQ-016 A misaligned request SHALL make no memory access, push nothing, and go to RESP with misalign=1 and load_data=0.
REQ-017 An aligned store SHALL push {addr word, wstrb, lane-shifted data} into the FIFO in the fire cycle, then go to RESP; it is posted and completes to WB before memory.
REQ-018 wstrb SHALL be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111. wdata SHALL be store_data<<(8*addr[1:0]).
REQ-019 An aligned load SHALL go to LD_REQ.
REQ-020 In LD_REQ, dmem_arvalid SHALL stay low while any valid FIFO entry has the same word address (addr[XLEN-1:2]); otherwise it SHALL be high with araddr equal to the latched word-aligned address.
REQ-021 arvalid and araddr SHALL hold stable until dmem_arready; on the handshake the FSM SHALL go to LD_WAIT.
REQ-022 dmem_rready SHALL be high only in LD_WAIT; on rvalid it SHALL capture rdata and go to RESP.
REQ-023 load_data SHALL take captured data >> 8*offset: LB sign-extend 8, LH sign-extend 16, LW whole, LBU zero-extend 8, LHU zero-extend 16, other funct3 0.
REQ-024 In RESP, out_valid=1 and load_data/misalign SHALL be held stable until in_ready; on that handshake the FSM SHALL go to IDLE.
REQ-025 out_valid SHALL be 0 in all states other than RESP.
REQ-026 Drain: dmem_wvalid SHALL equal !sb_empty and present the head entry, held stable until dmem_wready; pop on the handshake.
REQ-027 Drain SHALL run independently of the FSM.
REQ-028 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-029 Pointers SHALL wrap modulo SB_DEPTH; the count SHALL saturate neither above SB_DEPTH nor below 0.
REQ-030 When the FIFO is full, out_ready SHALL be 0 and no push is possible.
REQ-031 Responses SHALL return strictly in request order; the FSM SHALL have at most one load outstanding.

Reset
REQ-032 On rst, state SHALL be IDLE and FIFO pointers/count cleared; sb_empty=1.
REQ-033 On rst, out_valid, dmem_arvalid, dmem_rready, dmem_wvalid and misalign SHALL be 0, and load_data SHALL be 0.
REQ-034 Reset mid-transaction SHALL abandon pending loads and buffered stores without further memory handshakes.
REQ-035 After rst deasserts, out_ready SHALL be 1 in the first cycle.

Verification
REQ-036 SB addr 0x103, data 0xAB -> dmem_waddr 0x100, wstrb 4'b1000, wdata 0xAB000000; out_valid precedes the write handshake.
REQ-037 LH addr 0x201 -> no arvalid, misalign=1, load_data=0, sb_empty unchanged.
REQ-038 SW 0x300 with dmem_wready held 0, then LW 0x300 -> arvalid stays 0 until the write handshake, then the load completes and returns memory data.
REQ-039 LB addr 0x402, rdata 0x00800000 -> load_data 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SB_DEPTH=4, wready=0, five stores -> out_ready drops after the 4th push; raising wready drains entries in order with count wrap correct.
REQ-041 rst asserted during LD_WAIT -> next cycle IDLE, all valids 0, sb_empty=1.
